spec_readout_streamer: RTL and testbench

- Reader side of the accumulated power-spectrum DPRAM: 32-bit words, 16 range bins x 1024 FFT points, address = {range_bin[3:0], fft_bin[9:0]}.
- On start, sequentially reads a programmable window of FFT bins for N range bins.
- Streams each word out as two 16-bit lanes with valid/ready flow control.
- Sits between the DPRAM read port and the y0/y0z output path, in place of the direct doutb hookup.

---
 rtl/spec_readout_streamer_if.sv | 13 +
 rtl/spec_readout_streamer.sv | 238 +++++++++++++++++++++++
 tb/tb_spec_readout_streamer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spec_readout_streamer_if.sv
// Output word stream: two 16-bit lanes plus sob/eof tags, valid/ready handshake.
// master drives the word, slave returns ready.
interface spec_readout_streamer_if;
    logic        valid;
    logic        ready;
    logic [15:0] y0;
    logic [15:0] y0z;
    logic        sob;
    logic        eof;

    modport master (output valid, y0, y0z, sob, eof, input ready);
    modport slave  (input valid, y0, y0z, sob, eof, output ready);
endinterface

// File: rtl/spec_readout_streamer.sv
// Purpose: reads a window of FFT bins per range bin from the spectrum DPRAM and streams it (SPEC_RD_HEADER_EN adds per-bin header).
// Latency: first rd_en 1 cycle after start, first valid 2+RAM_LAT cycles after start; 1 word/cycle sustained.
// Backpressure: reads are credit-limited to FIFO_DEPTH in flight, so ready low stalls the reader, never drops data.
module srs_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          pop;

    assign pop     = out_vld && out_rdy;
    assign out_vld = (cnt != '0);
    assign out_dat = out_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_i) begin
        if (in_vld) mem[wr_ptr] <= in_dat;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (in_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, in_vld} - {{AW{1'b0}}, pop};
        end
    end
endmodule

module spec_readout_streamer #(
    parameter int RAM_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    start_i,
    input  logic [4:0]              range_bins_i,
    input  logic [9:0]              fft_lo_i,
    input  logic [10:0]             fft_len_i,
    output logic                    rd_en_o,
    output logic [13:0]             rd_addr_o,
    input  logic [31:0]             rd_data_i,
    spec_readout_streamer_if.master out_if,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    start_ign_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    typedef struct packed {
        logic        sob;
        logic        eof;
        logic [15:0] y0z;
        logic [15:0] y0;
    } word_t;

`ifdef SPEC_RD_HEADER_EN
    typedef struct packed {
        logic       vld;
        logic       hdr;
        logic       sob;
        logic       eof;
        logic [3:0] r;
    } slot_t;
    logic hdr_pend;
`else
    typedef struct packed {
        logic vld;
        logic sob;
        logic eof;
    } slot_t;
`endif

    state_t        state, state_nxt;
    logic [3:0]    r, rb_m1;
    logic [9:0]    k, lo, n, len_m1;
    logic [CW-1:0] credits;
    logic          issue, last_k, last_r, pop, fifo_vld;
    slot_t         slot_in, cap;
    slot_t         pipe [RAM_LAT];
    word_t         fifo_in, fifo_out;

    assign last_k      = (n == len_m1);
    assign last_r      = (r == rb_m1);
    assign pop         = out_if.valid && out_if.ready;
    assign rd_addr_o   = rd_en_o ? {r, k} : '0;
    assign start_ign_o = start_i && busy_o;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        rd_en_o   = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        slot_in   = '0;
        case (state)
            IDLE: if (start_i) state_nxt = (range_bins_i == 5'd0) ? FIN : READ;
            READ: begin
                busy_o = 1'b1;
                issue  = (credits < DEPTH_C);
`ifdef SPEC_RD_HEADER_EN
                rd_en_o = issue && !hdr_pend;
`else
                rd_en_o = issue;
`endif
                if (rd_en_o && last_k && last_r) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (credits == '0) state_nxt = FIN;
            end
            FIN: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        slot_in.vld = issue;
        slot_in.eof = rd_en_o && last_k && last_r;
`ifdef SPEC_RD_HEADER_EN
        slot_in.hdr = issue && hdr_pend;
        slot_in.sob = issue && hdr_pend;
        slot_in.r   = r;
`else
        slot_in.sob = rd_en_o && (n == '0);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    // Window counters: k wraps naturally at 1024, n counts reads within the current range bin.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r      <= '0;
            k      <= '0;
            lo     <= '0;
            n      <= '0;
            len_m1 <= '0;
            rb_m1  <= '0;
`ifdef SPEC_RD_HEADER_EN
            hdr_pend <= 1'b0;
`endif
        end else if (state == IDLE && start_i) begin
            r      <= '0;
            k      <= fft_lo_i;
            lo     <= fft_lo_i;
            n      <= '0;
            len_m1 <= 10'(fft_len_i - 11'd1);
            rb_m1  <= 4'(range_bins_i - 5'd1);
`ifdef SPEC_RD_HEADER_EN
            hdr_pend <= 1'b1;
`endif
        end else if (rd_en_o) begin
            if (last_k) begin
                n <= '0;
                k <= lo;
                r <= r + 4'd1;
`ifdef SPEC_RD_HEADER_EN
                hdr_pend <= 1'b1;
`endif
            end else begin
                n <= n + 10'd1;
                k <= k + 10'd1;
            end
`ifdef SPEC_RD_HEADER_EN
        end else if (issue) begin
            hdr_pend <= 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) credits <= '0;
        else          credits <= credits + CW'(issue) - CW'(pop);
    end

    // Slot tags ride alongside the RAM access so the capture lines up with rd_data_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < RAM_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= slot_in;
            for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign cap = pipe[RAM_LAT-1];

    always_comb begin
        fifo_in     = '0;
        fifo_in.sob = cap.sob;
        fifo_in.eof = cap.eof;
        fifo_in.y0  = rd_data_i[15:0];
        fifo_in.y0z = rd_data_i[31:16];
`ifdef SPEC_RD_HEADER_EN
        if (cap.hdr) begin
            fifo_in.y0  = {12'b0, cap.r};
            fifo_in.y0z = 16'hA55A;
        end
`endif
    end

    srs_fifo #(.W($bits(word_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .in_vld  (cap.vld),
        .in_dat  (fifo_in),
        .out_vld (fifo_vld),
        .out_rdy (out_if.ready),
        .out_dat (fifo_out)
    );

    assign out_if.valid = fifo_vld;
    assign out_if.y0    = fifo_out.y0;
    assign out_if.y0z   = fifo_out.y0z;
    assign out_if.sob   = fifo_out.sob;
    assign out_if.eof   = fifo_out.eof;
endmodule

// File: tb/tb_spec_readout_streamer.sv
// Directed bench for spec_readout_streamer: DPRAM model with word = {2'b0, addr, addr+0x100}, RAM_LAT=1, FIFO_DEPTH=4.
module tb_spec_readout_streamer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  rb_in = '0;
    logic [9:0]  lo_in = '0;
    logic [10:0] len_in = '0;
    logic        rd_en;
    logic [13:0] rd_addr;
    logic [31:0] rd_data = '0;
    logic        busy, done, start_ign;
    logic        ready_r = 1'b1;
    logic [3:0]  pat = 4'b1001;

    typedef struct packed {
        logic        sob;
        logic        eof;
        logic [15:0] y0z;
        logic [15:0] y0;
    } obs_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    spec_readout_streamer_if sif();
    assign sif.ready = ready_r;

    spec_readout_streamer #(.RAM_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .range_bins_i (rb_in),
        .fft_lo_i     (lo_in),
        .fft_len_i    (len_in),
        .rd_en_o      (rd_en),
        .rd_addr_o    (rd_addr),
        .rd_data_i    (rd_data),
        .out_if       (sif),
        .busy_o       (busy),
        .done_o       (done),
        .start_ign_o  (start_ign)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rd_en) rd_data <= {2'b00, rd_addr, 16'(rd_addr) + 16'h0100};

    // Monitor: samples on the falling edge, logs handshakes, reads, pulses and protocol violations.
    obs_t        word_q[$];
    int          hs_q[$];
    logic [13:0] addr_q[$];
    int          rd_q[$];
    int          n_done = 0, done_cyc = 0, n_ign = 0, cred_viol = 0, stab_viol = 0, tb_cred = 0;
    logic        stalled = 1'b0;
    obs_t        prev = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                addr_q.push_back(rd_addr);
                rd_q.push_back(cyc);
                if (tb_cred >= 4) cred_viol++;
            end
            if (stalled && (sif.valid !== 1'b1 || {sif.sob, sif.eof, sif.y0z, sif.y0} !== prev)) stab_viol++;
            if (sif.valid && sif.ready) begin
                word_q.push_back({sif.sob, sif.eof, sif.y0z, sif.y0});
                hs_q.push_back(cyc);
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (start_ign) n_ign++;
            stalled = sif.valid && !sif.ready;
            prev    = {sif.sob, sif.eof, sif.y0z, sif.y0};
            tb_cred = tb_cred + int'(rd_en) - int'(sif.valid && sif.ready);
        end else begin
            tb_cred = 0;
            stalled = 1'b0;
        end
    end

    function automatic obs_t exp_word(input int rb, input int lo, input int len, input int j);
        obs_t        e;
        logic [9:0]  kk;
        logic [13:0] a;
        kk    = 10'((lo + (j % len)) % 1024);
        a     = {4'(j / len), kk};
        e.y0z = {2'b00, a};
        e.y0  = {2'b00, a} + 16'h0100;
        e.sob = ((j % len) == 0);
        e.eof = (j == rb * len - 1);
        return e;
    endfunction

    task automatic run_frame(input int rb, input int lo, input int len, input bit toggle,
                             input int ign_at, output int s_cyc, output bit got);
        int d0;
        d0 = n_done;
        @(posedge clk); #1;
        start  = 1'b1;
        rb_in  = 5'(rb);
        lo_in  = 10'(lo);
        len_in = 11'(len);
        s_cyc  = cyc;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start = (i + 1 == ign_at);
            if (start) begin
                rb_in = 5'd3;
                lo_in = 10'd100;
            end
            ready_r = toggle ? pat[i % 4] : 1'b1;
            if (n_done != d0) break;
        end
        start   = 1'b0;
        ready_r = 1'b1;
        got     = (n_done != d0);
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        tests++;
        if ({sif.valid, sif.y0, sif.y0z, sif.sob, sif.eof} !== '0) begin
            fails++;
            $display("FAIL reset_stream: got %h required 0", {sif.valid, sif.y0, sif.y0z, sif.sob, sif.eof});
        end
        tests++;
        if ({rd_en, rd_addr, busy, done, start_ign} !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: got %h required 0", {rd_en, rd_addr, busy, done, start_ign});
        end
    endtask

    task automatic test_basic(input bit toggle);
        int w0, a0, d0, cv0, sv0, s;
        bit got;
        w0 = word_q.size(); a0 = addr_q.size(); d0 = n_done; cv0 = cred_viol; sv0 = stab_viol;
        run_frame(2, 0, 4, toggle, -1, s, got);
        tests++;
        if (!got) begin fails++; $display("FAIL basic_done_timeout: got no done required done"); end
        tests++;
        if (word_q.size() - w0 != 8) begin
            fails++; $display("FAIL basic_count: got %0d required 8", word_q.size() - w0);
        end
        tests++;
        if (n_done - d0 != 1) begin fails++; $display("FAIL basic_done_pulses: got %0d required 1", n_done - d0); end
        for (int j = 0; j < 8 && w0 + j < word_q.size(); j++) begin
            tests++;
            if (word_q[w0+j] !== exp_word(2, 0, 4, j)) begin
                fails++; $display("FAIL basic_word[%0d]: got %h required %h", j, word_q[w0+j], exp_word(2, 0, 4, j));
            end
            if (!toggle) begin
                tests++;
                if (hs_q[w0+j] != s + 3 + j) begin
                    fails++; $display("FAIL basic_hs_cycle[%0d]: got %0d required %0d", j, hs_q[w0+j] - s, 3 + j);
                end
            end
        end
        if (!toggle && addr_q.size() > a0) begin
            tests++;
            if (rd_q[a0] != s + 1) begin fails++; $display("FAIL first_rd_cycle: got %0d required 1", rd_q[a0] - s); end
        end
        if (word_q.size() - w0 == 8) begin
            tests++;
            if (done_cyc != hs_q[w0+7] + 2) begin
                fails++; $display("FAIL done_after_eof: got %0d required 2", done_cyc - hs_q[w0+7]);
            end
        end
        tests++;
        if (cred_viol != cv0) begin fails++; $display("FAIL credit_overrun: got %0d required 0", cred_viol - cv0); end
        tests++;
        if (stab_viol != sv0) begin fails++; $display("FAIL stall_stability: got %0d required 0", stab_viol - sv0); end
    endtask

    task automatic test_wrap();
        int a0, s;
        bit got;
        logic [13:0] ea [4];
        ea[0] = 14'd1022; ea[1] = 14'd1023; ea[2] = 14'd0; ea[3] = 14'd1;
        a0 = addr_q.size();
        run_frame(1, 1022, 4, 1'b0, -1, s, got);
        tests++;
        if (!got || addr_q.size() - a0 != 4) begin
            fails++; $display("FAIL wrap_count: got %0d required 4", addr_q.size() - a0);
        end
        for (int j = 0; j < 4 && a0 + j < addr_q.size(); j++) begin
            tests++;
            if (addr_q[a0+j] !== ea[j]) begin
                fails++; $display("FAIL wrap_addr[%0d]: got %0d required %0d", j, addr_q[a0+j], ea[j]);
            end
        end
    endtask

    task automatic test_zero();
        int a0, w0, s;
        bit got;
        a0 = addr_q.size(); w0 = word_q.size();
        run_frame(0, 7, 4, 1'b0, -1, s, got);
        tests++;
        if (!got || done_cyc != s + 1) begin
            fails++; $display("FAIL zero_done_cycle: got %0d required 1", done_cyc - s);
        end
        tests++;
        if (addr_q.size() != a0 || word_q.size() != w0) begin
            fails++; $display("FAIL zero_traffic: got %0d reads %0d words required 0 0", addr_q.size() - a0, word_q.size() - w0);
        end
    endtask

    task automatic test_start_ignored();
        int w0, i0, s;
        bit got;
        w0 = word_q.size(); i0 = n_ign;
        run_frame(2, 0, 4, 1'b0, 3, s, got);
        tests++;
        if (n_ign - i0 != 1) begin fails++; $display("FAIL ign_pulses: got %0d required 1", n_ign - i0); end
        tests++;
        if (!got || word_q.size() - w0 != 8) begin
            fails++; $display("FAIL ign_count: got %0d required 8", word_q.size() - w0);
        end
        for (int j = 0; j < 8 && w0 + j < word_q.size(); j++) begin
            tests++;
            if (word_q[w0+j] !== exp_word(2, 0, 4, j)) begin
                fails++; $display("FAIL ign_word[%0d]: got %h required %h", j, word_q[w0+j], exp_word(2, 0, 4, j));
            end
        end
    endtask

    task automatic test_single();
        int w0, s;
        bit got;
        w0 = word_q.size();
        run_frame(1, 5, 1, 1'b0, -1, s, got);
        tests++;
        if (!got || word_q.size() - w0 != 1) begin
            fails++; $display("FAIL single_count: got %0d required 1", word_q.size() - w0);
        end else begin
            tests++;
            if (word_q[w0] !== {1'b1, 1'b1, 16'h0005, 16'h0105}) begin
                fails++; $display("FAIL single_word: got %h required %h", word_q[w0], {1'b1, 1'b1, 16'h0005, 16'h0105});
            end
        end
    endtask

    task automatic test_reset_mid();
        int w0, d0, s;
        bit got;
        w0 = word_q.size(); d0 = n_done;
        @(posedge clk); #1;
        start = 1'b1; rb_in = 5'd4; lo_in = 10'd0; len_in = 11'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 100 && word_q.size() - w0 < 3; i++) @(posedge clk);
        tests++;
        if (word_q.size() - w0 != 3) begin
            fails++; $display("FAIL rstmid_progress: got %0d required 3", word_q.size() - w0);
        end
        #3 rst_n = 1'b0;
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        tests++;
        if (n_done != d0) begin fails++; $display("FAIL rstmid_done: got %0d required 0", n_done - d0); end
        w0 = word_q.size();
        run_frame(4, 0, 4, 1'b0, -1, s, got);
        tests++;
        if (!got || word_q.size() - w0 != 16) begin
            fails++; $display("FAIL rstmid_refill_count: got %0d required 16", word_q.size() - w0);
        end
        for (int j = 0; j < 16 && w0 + j < word_q.size(); j++) begin
            tests++;
            if (word_q[w0+j] !== exp_word(4, 0, 4, j)) begin
                fails++; $display("FAIL rstmid_word[%0d]: got %h required %h", j, word_q[w0+j], exp_word(4, 0, 4, j));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        test_basic(1'b0);
        test_wrap();
        test_basic(1'b1);
        test_zero();
        test_start_ignored();
        test_single();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
